// File: rtl/out_store_ctrl_if.sv
// Bundles the row-capture request, the result rows and the host-side FIFO read port of out_store_ctrl.
// master drives requests and reads; slave is the controller itself.
interface out_store_ctrl_if #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int OS_WIDTH     = 40,
  parameter int FIFO_DEPTH   = 16
);
  logic                          clear_fifo;
  logic                          store_os;
  logic [3:0]                    param_r;
  logic [OS_WIDTH-1:0]           os_wr_data_0;
  logic [OS_WIDTH-1:0]           os_wr_data_1;
  logic [OS_WIDTH-1:0]           os_wr_data_2;
  logic [OS_WIDTH-1:0]           os_wr_data_3;
  logic [OS_WIDTH-1:0]           os_wr_data_4;
  logic                          storing_os;
  logic                          os_done;
  logic                          fifo_rd_cmd;
  logic [OUTPUT_WIDTH-1:0]       fifo_rd_data;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output clear_fifo, store_os, param_r,
    output os_wr_data_0, os_wr_data_1, os_wr_data_2, os_wr_data_3, os_wr_data_4,
    output fifo_rd_cmd,
    input  storing_os, os_done, fifo_rd_data, fifo_empty, fifo_full, fifo_count
  );

  modport slave (
    input  clear_fifo, store_os, param_r,
    input  os_wr_data_0, os_wr_data_1, os_wr_data_2, os_wr_data_3, os_wr_data_4,
    input  fifo_rd_cmd,
    output storing_os, os_done, fifo_rd_data, fifo_empty, fifo_full, fifo_count
  );
endinterface

// File: rtl/out_store_ctrl.sv
// Output-store readout: snapshots up to OS_DEPTH result rows and pushes their MSB-justified
// slices into a host-drained FIFO.
//
// state | meaning
// IDLE  | waiting for a valid store request
// PUSH  | writing snapshot rows into the FIFO, stalls while full
// DONE  | one-cycle completion pulse
module out_store_ctrl #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int OS_WIDTH     = 40,
  parameter int OS_DEPTH     = 5,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  out_store_ctrl_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(OS_DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, DONE} state_t;

  state_t                   state, state_nxt;
  logic [OS_WIDTH-1:0]      rows_in [OS_DEPTH];
  logic [OS_WIDTH-1:0]      snap    [OS_DEPTH];
  logic [OUTPUT_WIDTH-1:0]  mem     [FIFO_DEPTH];
  logic [3:0]               rows_r;
  logic [IW-1:0]            idx;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, count_nxt;
  logic                     empty, full;
  logic [OUTPUT_WIDTH-1:0]  rd_data;
  logic                     req_ok, push, pop, last_row;
  logic [OUTPUT_WIDTH-1:0]  push_word;

  assign rows_in[0] = bus.os_wr_data_0;
  assign rows_in[1] = bus.os_wr_data_1;
  assign rows_in[2] = bus.os_wr_data_2;
  assign rows_in[3] = bus.os_wr_data_3;
  assign rows_in[4] = bus.os_wr_data_4;

  assign req_ok    = bus.store_os && (bus.param_r != 4'd0) && (bus.param_r <= 4'(OS_DEPTH));
  assign push      = (state == PUSH) && !full;
  assign pop       = bus.fifo_rd_cmd && !empty;
  assign last_row  = (4'(idx) == rows_r - 4'd1);
  assign push_word = snap[idx][OS_WIDTH-1 -: OUTPUT_WIDTH];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ok) state_nxt = PUSH;
      PUSH:    if (push && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.clear_fifo) state_nxt = IDLE;
  end

  always_comb begin
    bus.storing_os = (state == PUSH);
    bus.os_done    = (state == DONE);
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
      rows_r  <= '0;
      idx     <= '0;
      for (int i = 0; i < OS_DEPTH; i++) snap[i] <= '0;
    end else if (bus.clear_fifo) begin
      // read data deliberately survives a flush
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      idx    <= '0;
    end else begin
      if (state == IDLE && req_ok) begin
        for (int i = 0; i < OS_DEPTH; i++) snap[i] <= rows_in[i];
        rows_r <= bus.param_r;
        idx    <= '0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        idx    <= idx + IW'(1);
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !bus.clear_fifo && push) mem[wr_ptr] <= push_word;
  end

  assign bus.fifo_rd_data = rd_data;
  assign bus.fifo_empty   = empty;
  assign bus.fifo_full    = full;
  assign bus.fifo_count   = count;
endmodule

// File: tb/tb_out_store_ctrl.sv
// Randomized bench for out_store_ctrl against a queue-based model of the row drain and FIFO.
module tb_out_store_ctrl;
  localparam int OW = 32;
  localparam int SW = 40;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  out_store_ctrl_if #(.OUTPUT_WIDTH(OW), .OS_WIDTH(SW), .FIFO_DEPTH(FD)) bus ();

  out_store_ctrl #(.OUTPUT_WIDTH(OW), .OS_WIDTH(SW), .OS_DEPTH(5), .FIFO_DEPTH(FD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [OW-1:0] m_q[$];
  logic [OW-1:0] m_pend[$];
  logic          m_done;
  logic [OW-1:0] m_rd;
  int            n_done_seen = 0;

  function automatic logic [OW-1:0] slice_row(input logic [SW-1:0] row);
    return OW'(row >> (SW - OW));
  endfunction

  task automatic model_step();
    bit was_idle, do_pop, do_push, nd;
    logic [SW-1:0] rows [5];
    rows[0] = bus.os_wr_data_0; rows[1] = bus.os_wr_data_1; rows[2] = bus.os_wr_data_2;
    rows[3] = bus.os_wr_data_3; rows[4] = bus.os_wr_data_4;
    if (!resetn) begin
      m_q.delete(); m_pend.delete(); m_done = 1'b0; m_rd = '0;
    end else if (bus.clear_fifo) begin
      m_q.delete(); m_pend.delete(); m_done = 1'b0;
    end else begin
      was_idle = (m_pend.size() == 0) && !m_done;
      do_pop   = bus.fifo_rd_cmd && (m_q.size() > 0);
      do_push  = (m_pend.size() > 0) && (m_q.size() < FD);
      nd = 1'b0;
      if (do_pop) m_rd = m_q.pop_front();
      if (do_push) begin
        m_q.push_back(m_pend.pop_front());
        if (m_pend.size() == 0) nd = 1'b1;
      end
      if (was_idle && bus.store_os && bus.param_r >= 1 && bus.param_r <= 5)
        for (int i = 0; i < int'(bus.param_r); i++) m_pend.push_back(slice_row(rows[i]));
      m_done = nd;
    end
  endtask

  task automatic check_outputs();
    chk("count",   64'(bus.fifo_count),   64'(m_q.size()));
    chk("empty",   64'(bus.fifo_empty),   64'(m_q.size() == 0));
    chk("full",    64'(bus.fifo_full),    64'(m_q.size() == FD));
    chk("rd_data", 64'(bus.fifo_rd_data), 64'(m_rd));
    chk("storing", 64'(bus.storing_os),   64'(m_pend.size() > 0));
    chk("os_done", 64'(bus.os_done),      64'(m_done));
    if (m_done) n_done_seen++;
  endtask

  function automatic logic [SW-1:0] rnd_row();
    return {8'($urandom), 32'($urandom)};
  endfunction

  initial begin
    int phase, rd_pct, st_pct, clr_pct, rst_pct;
    resetn = 1'b0;
    bus.clear_fifo = 1'b0; bus.store_os = 1'b0; bus.param_r = 4'd0; bus.fifo_rd_cmd = 1'b0;
    bus.os_wr_data_0 = rnd_row(); bus.os_wr_data_1 = rnd_row(); bus.os_wr_data_2 = rnd_row();
    bus.os_wr_data_3 = rnd_row(); bus.os_wr_data_4 = rnd_row();
    m_done = 1'b0; m_rd = '0;
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      phase = cyc / 600;
      case (phase)
        0:       begin rd_pct = 0;   st_pct = 30; clr_pct = 0; rst_pct = 0; end
        1:       begin rd_pct = 100; st_pct = 40; clr_pct = 0; rst_pct = 0; end
        2:       begin rd_pct = 50;  st_pct = 35; clr_pct = 0; rst_pct = 0; end
        3:       begin rd_pct = 30;  st_pct = 40; clr_pct = 3; rst_pct = 0; end
        default: begin rd_pct = 40;  st_pct = 40; clr_pct = 2; rst_pct = 1; end
      endcase
      resetn          = ($urandom_range(99) >= rst_pct);
      bus.clear_fifo  = ($urandom_range(99) < clr_pct);
      bus.store_os    = ($urandom_range(99) < st_pct);
      bus.param_r     = ($urandom_range(99) < 80) ? 4'($urandom_range(1, 5))
                                                  : (($urandom_range(1) != 0) ? 4'd0 : 4'($urandom_range(6, 15)));
      bus.fifo_rd_cmd = ($urandom_range(99) < rd_pct);
      bus.os_wr_data_0 = rnd_row(); bus.os_wr_data_1 = rnd_row(); bus.os_wr_data_2 = rnd_row();
      bus.os_wr_data_3 = rnd_row(); bus.os_wr_data_4 = rnd_row();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end

    chk("done_pulses_seen", 64'(n_done_seen > 0), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
